// File: rtl/game_flow_controller.sv
// Pong game sequencer: IDLE -> SERVE -> PLAY -> POINT ... -> GAME_OVER.
// Owns both score counters and gates the ball datapath; paced by per-frame timing_tick.
module game_flow_controller #(
  parameter int WIN_SCORE          = 5,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_HOLD_FRAMES  = 90,
  parameter int SCORE_W            = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic               start,
  input  logic               ball_out_left,
  input  logic               ball_out_right,
  output logic               ball_rst,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_dbg
);

  localparam int MAX_FRAMES = (SERVE_DELAY_FRAMES > POINT_HOLD_FRAMES) ?
                              SERVE_DELAY_FRAMES : POINT_HOLD_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SCORE_W-1:0] r_score_left, w_score_left_nxt;
  logic [SCORE_W-1:0] r_score_right, w_score_right_nxt;
  logic               r_serve_dir, w_serve_dir_nxt;
  logic               r_winner, w_winner_nxt;
  logic               r_start_q;
  logic               r_ball_rst, w_ball_rst_nxt;
  logic               r_ball_run, w_ball_run_nxt;
  logic               r_game_over, w_game_over_nxt;

  logic               w_start_edge;
  logic [SCORE_W-1:0] w_score_left_inc, w_score_right_inc;

  assign w_start_edge      = start & ~r_start_q;
  assign w_score_left_inc  = r_score_left + SCORE_W'(1);
  assign w_score_right_inc = r_score_right + SCORE_W'(1);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_state_nxt       = r_state;
    w_cnt_nxt         = '0;
    w_score_left_nxt  = r_score_left;
    w_score_right_nxt = r_score_right;
    w_serve_dir_nxt   = r_serve_dir;
    w_winner_nxt      = r_winner;

    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_score_left_nxt  = '0;
          w_score_right_nxt = '0;
          w_serve_dir_nxt   = 1'b1;
          w_state_nxt       = S_SERVE;
        end
      end
      S_SERVE: begin
        w_cnt_nxt = r_cnt;
        if (timing_tick) begin
          if (r_cnt == CNT_W'(SERVE_DELAY_FRAMES - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_PLAY;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        // Left-edge exit takes priority when both edges report in one cycle.
        if (ball_out_left) begin
          w_score_right_nxt = w_score_right_inc;
          w_serve_dir_nxt   = 1'b0;
          if (w_score_right_inc == SCORE_W'(WIN_SCORE)) begin
            w_winner_nxt = 1'b1;
            w_state_nxt  = S_GAME_OVER;
          end else begin
            w_state_nxt = S_POINT;
          end
        end else if (ball_out_right) begin
          w_score_left_nxt = w_score_left_inc;
          w_serve_dir_nxt  = 1'b1;
          if (w_score_left_inc == SCORE_W'(WIN_SCORE)) begin
            w_winner_nxt = 1'b0;
            w_state_nxt  = S_GAME_OVER;
          end else begin
            w_state_nxt = S_POINT;
          end
        end
      end
      S_POINT: begin
        w_cnt_nxt = r_cnt;
        if (timing_tick) begin
          if (r_cnt == CNT_W'(POINT_HOLD_FRAMES - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_SERVE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_GAME_OVER: begin
        if (w_start_edge) begin
          w_score_left_nxt  = '0;
          w_score_right_nxt = '0;
          w_winner_nxt      = 1'b0;
          w_serve_dir_nxt   = 1'b1;
          w_state_nxt       = S_SERVE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Datapath controls are decoded from the next state so they register alongside it.
    w_ball_rst_nxt  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_SERVE) ||
                      (w_state_nxt == S_GAME_OVER);
    w_ball_run_nxt  = (w_state_nxt == S_PLAY);
    w_game_over_nxt = (w_state_nxt == S_GAME_OVER);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_score_left  <= '0;
      r_score_right <= '0;
      r_serve_dir   <= 1'b1;
      r_winner      <= 1'b0;
      r_start_q     <= 1'b1;
      r_ball_rst    <= 1'b1;
      r_ball_run    <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_score_left  <= w_score_left_nxt;
      r_score_right <= w_score_right_nxt;
      r_serve_dir   <= w_serve_dir_nxt;
      r_winner      <= w_winner_nxt;
      r_start_q     <= start;
      r_ball_rst    <= w_ball_rst_nxt;
      r_ball_run    <= w_ball_run_nxt;
      r_game_over   <= w_game_over_nxt;
    end
  end

  assign ball_rst    = r_ball_rst;
  assign ball_run    = r_ball_run;
  assign serve_dir   = r_serve_dir;
  assign score_left  = r_score_left;
  assign score_right = r_score_right;
  assign game_over   = r_game_over;
  assign winner      = r_winner;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a behavioural game model.
module tb_game_flow_controller;

  localparam int WIN_SCORE          = 5;
  localparam int SERVE_DELAY_FRAMES = 4;
  localparam int POINT_HOLD_FRAMES  = 3;
  localparam int SCORE_W            = 4;
  localparam int N_VEC              = 24;
  localparam int N_RAND             = 3000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               timing_tick = 1'b0;
  logic               start = 1'b0;
  logic               ball_out_left = 1'b0;
  logic               ball_out_right = 1'b0;
  logic               ball_rst, ball_run, serve_dir, game_over, winner;
  logic [SCORE_W-1:0] score_left, score_right;
  logic [2:0]         state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  game_flow_controller #(
    .WIN_SCORE         (WIN_SCORE),
    .SERVE_DELAY_FRAMES(SERVE_DELAY_FRAMES),
    .POINT_HOLD_FRAMES (POINT_HOLD_FRAMES),
    .SCORE_W           (SCORE_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .timing_tick   (timing_tick),
    .start         (start),
    .ball_out_left (ball_out_left),
    .ball_out_right(ball_out_right),
    .ball_rst      (ball_rst),
    .ball_run      (ball_run),
    .serve_dir     (serve_dir),
    .score_left    (score_left),
    .score_right   (score_right),
    .game_over     (game_over),
    .winner        (winner),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  // Behavioural model: game phase plus frames elapsed in the current phase.
  int m_phase, m_frames, m_left, m_right, m_dir, m_win, m_prev_start;

  task automatic new_game();
    m_left = 0; m_right = 0; m_dir = 1; m_win = 0; m_frames = 0; m_phase = 1;
  endtask

  task automatic model_step(input bit r, input bit tk, input bit st,
                            input bit ol, input bit orr);
    bit rise;
    if (r) begin
      m_phase = 0; m_frames = 0; m_left = 0; m_right = 0;
      m_dir = 1; m_win = 0; m_prev_start = 1;
      return;
    end
    rise = st && !m_prev_start;
    m_prev_start = st;
    case (m_phase)
      0: if (rise) new_game();
      1: if (tk) begin
           m_frames++;
           if (m_frames == SERVE_DELAY_FRAMES) begin m_phase = 2; m_frames = 0; end
         end
      2: if (ol) begin
           m_right++; m_dir = 0;
           if (m_right == WIN_SCORE) begin m_phase = 4; m_win = 1; end
           else m_phase = 3;
         end else if (orr) begin
           m_left++; m_dir = 1;
           if (m_left == WIN_SCORE) begin m_phase = 4; m_win = 0; end
           else m_phase = 3;
         end
      3: if (tk) begin
           m_frames++;
           if (m_frames == POINT_HOLD_FRAMES) begin m_phase = 1; m_frames = 0; end
         end
      default: if (rise) new_game();
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit tk, input bit st, input bit ol, input bit orr);
    rst = r; timing_tick = tk; start = st; ball_out_left = ol; ball_out_right = orr;
    @(posedge clk);
    #1;
    model_step(r, tk, st, ol, orr);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"},    32'(state_dbg),   32'(m_phase));
    check({tag, ".score_l"},  32'(score_left),  32'(m_left));
    check({tag, ".score_r"},  32'(score_right), 32'(m_right));
    check({tag, ".dir"},      32'(serve_dir),   32'(m_dir));
    check({tag, ".ball_rst"}, 32'(ball_rst),    32'(m_phase == 0 || m_phase == 1 || m_phase == 4));
    check({tag, ".ball_run"}, 32'(ball_run),    32'(m_phase == 2));
    check({tag, ".game_over"}, 32'(game_over),  32'(m_phase == 4));
    if (m_phase == 4) check({tag, ".winner"}, 32'(winner), 32'(m_win));
  endtask

  task automatic step_chk(input string tag, input bit tk, input bit st,
                          input bit ol, input bit orr);
    cyc(1'b0, tk, st, ol, orr);
    check_model(tag);
  endtask

  typedef struct {
    bit r, tk, st, ol, orr;
    int st_e, sl_e, sr_e, dir_e, brst_e, run_e, go_e, win_e;
  } vec_t;

  vec_t vecs [N_VEC];

  initial begin
    //        r  tk st ol or | state sl sr dir brst run go win
    vecs[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0};
    vecs[1]  = '{1, 0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0};
    vecs[6]  = '{0, 0, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0};
    vecs[11] = '{0, 1, 1, 0, 0,  2, 0, 0, 1, 0, 1, 0, 0};
    vecs[12] = '{0, 1, 1, 0, 0,  2, 0, 0, 1, 0, 1, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 1,  3, 1, 0, 1, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 1, 0,  3, 1, 0, 1, 0, 0, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 0,  3, 1, 0, 1, 0, 0, 0, 0};
    vecs[16] = '{0, 1, 0, 0, 0,  3, 1, 0, 1, 0, 0, 0, 0};
    vecs[17] = '{0, 1, 0, 0, 0,  1, 1, 0, 1, 1, 0, 0, 0};
    vecs[18] = '{0, 1, 0, 0, 0,  1, 1, 0, 1, 1, 0, 0, 0};
    vecs[19] = '{0, 1, 0, 0, 0,  1, 1, 0, 1, 1, 0, 0, 0};
    vecs[20] = '{0, 1, 0, 0, 0,  1, 1, 0, 1, 1, 0, 0, 0};
    vecs[21] = '{0, 1, 0, 0, 0,  2, 1, 0, 1, 0, 1, 0, 0};
    vecs[22] = '{0, 0, 0, 1, 1,  3, 1, 1, 0, 0, 0, 0, 0};
    vecs[23] = '{0, 0, 1, 0, 0,  3, 1, 1, 0, 0, 0, 0, 0};

    // Directed vector table.
    for (int i = 0; i < N_VEC; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cyc(vecs[i].r, vecs[i].tk, vecs[i].st, vecs[i].ol, vecs[i].orr);
      check({t, ".state"},     32'(state_dbg),   32'(vecs[i].st_e));
      check({t, ".score_l"},   32'(score_left),  32'(vecs[i].sl_e));
      check({t, ".score_r"},   32'(score_right), 32'(vecs[i].sr_e));
      check({t, ".dir"},       32'(serve_dir),   32'(vecs[i].dir_e));
      check({t, ".ball_rst"},  32'(ball_rst),    32'(vecs[i].brst_e));
      check({t, ".ball_run"},  32'(ball_run),    32'(vecs[i].run_e));
      check({t, ".game_over"}, 32'(game_over),   32'(vecs[i].go_e));
      check({t, ".winner"},    32'(winner),      32'(vecs[i].win_e));
    end

    // Left-edge points until the right side wins.
    for (int k = 2; k <= WIN_SCORE; k++) begin
      for (int j = 0; j < POINT_HOLD_FRAMES; j++) step_chk("win.hold", 1, 0, 0, 0);
      for (int j = 0; j < SERVE_DELAY_FRAMES; j++) step_chk("win.serve", 1, 0, 0, 0);
      step_chk("win.point", 0, 0, 1, 0);
    end
    check("win.state", 32'(state_dbg), 32'd4);
    check("win.game_over", 32'(game_over), 32'd1);
    check("win.winner", 32'(winner), 32'd1);
    check("win.score_r", 32'(score_right), 32'(WIN_SCORE));
    step_chk("go.out_l", 0, 0, 1, 0);
    step_chk("go.out_r", 0, 0, 0, 1);
    for (int j = 0; j < 6; j++) step_chk("go.tick", 1, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("restart.state", 32'(state_dbg), 32'd1);
    check("restart.score_l", 32'(score_left), 32'd0);
    check("restart.score_r", 32'(score_right), 32'd0);
    check("restart.game_over", 32'(game_over), 32'd0);
    check("restart.dir", 32'(serve_dir), 32'd1);

    // Build a 3:2 score, then reset mid-POINT.
    begin
      bit pts [5];
      pts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int p = 0; p < 5; p++) begin
        for (int j = 0; j < SERVE_DELAY_FRAMES; j++) step_chk("mid.serve", 1, 0, 0, 0);
        step_chk("mid.point", 0, 0, pts[p], !pts[p]);
        if (p < 4) for (int j = 0; j < POINT_HOLD_FRAMES; j++) step_chk("mid.hold", 1, 0, 0, 0);
      end
    end
    check("mid.state", 32'(state_dbg), 32'd3);
    check("mid.score_l", 32'(score_left), 32'd3);
    check("mid.score_r", 32'(score_right), 32'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.state", 32'(state_dbg), 32'd0);
    check("rst.score_l", 32'(score_left), 32'd0);
    check("rst.score_r", 32'(score_right), 32'd0);
    check("rst.ball_rst", 32'(ball_rst), 32'd1);
    check("rst.ball_run", 32'(ball_run), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("idle.state", 32'(state_dbg), 32'd0);
    check("idle.score_l", 32'(score_left), 32'd0);
    check("idle.score_r", 32'(score_right), 32'd0);

    // Randomized play against the model.
    begin
      bit st_lvl;
      st_lvl = 1'b0;
      for (int i = 0; i < N_RAND; i++) begin
        bit r, tk, ol, orr;
        r   = ($urandom_range(0, 399) == 0);
        tk  = ($urandom_range(0, 9) < 3);
        ol  = ($urandom_range(0, 19) == 0);
        orr = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 29) == 0) st_lvl = !st_lvl;
        cyc(r, tk, st_lvl, ol, orr);
        check_model("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level Pong game sequencer in the 65 MHz domain, alongside player_pad_controller and top_vga.
- Sequences IDLE -> SERVE -> PLAY -> POINT -> ... -> GAME_OVER.
- Owns both score counters and gates the ball datapath: hold/reset, run enable, serve direction.
- Paced by the per-frame timing_tick from top_vga. Out-of-bounds events come from the ball logic.

Parameters:
- WIN_SCORE, 5, score at which a side wins (1..2**SCORE_W-1).
- SERVE_DELAY_FRAMES, 60, timing_tick count spent in SERVE before PLAY (>=1).
- POINT_HOLD_FRAMES, 90, timing_tick count spent in POINT before next SERVE (>=1).
- SCORE_W, 4, width of each score counter.

Ports:
- clk  input  1  system clock (65 MHz pixel clock domain).
- rst  input  1  synchronous active-high reset.
- timing_tick  input  1  one-cycle pulse per video frame.
- start  input  1  start/restart request, level (button or key); rising edge detected internally.
- ball_out_left  input  1  one-cycle pulse: ball passed the left (player) edge.
- ball_out_right  input  1  one-cycle pulse: ball passed the right (opponent) edge.
- ball_rst  output  1  high: ball datapath held at centre.
- ball_run  output  1  high: ball datapath advances on timing_tick.
- serve_dir  output  1  0 = serve toward left, 1 = serve toward right.
- score_left  output  SCORE_W  left player score.
- score_right  output  SCORE_W  right player score.
- game_over  output  1  high while in GAME_OVER.
- winner  output  1  0 = left won, 1 = right won; valid only while game_over=1.
- state_dbg  output  3  encoded state: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.

Behaviour:
- One clock, synchronous active-high reset.
- All outputs are registered Moore outputs. An input event changes outputs on the next clk edge (latency 1 cycle).
- Reset values:
  - state IDLE; both scores 0; serve_dir 1; winner 0; game_over 0; ball_run 0; ball_rst 1; frame counter 0.
  - start edge-detect register resets to 1, so start held through reset does not trigger a game.
- start_edge = start & ~start_q, where start_q is start delayed one cycle.
- IDLE:
  - ball_rst=1, ball_run=0.
  - On start_edge: clear scores, serve_dir=1, counter=0, go to SERVE.
- SERVE:
  - ball_rst=1, ball_run=0.
  - Counter increments on each timing_tick.
  - On a tick with counter==SERVE_DELAY_FRAMES-1: counter=0, go to PLAY. So PLAY is entered exactly SERVE_DELAY_FRAMES ticks after SERVE entry.
- PLAY:
  - ball_rst=0, ball_run=1.
  - ball_out_left: score_right+1, serve_dir=0 (serve toward the side that lost the point).
  - ball_out_right: score_left+1, serve_dir=1.
  - If the incremented score == WIN_SCORE: go to GAME_OVER and set winner (right for out_left, left for out_right). Otherwise go to POINT with counter=0.
  - Both out pulses in the same cycle: ball_out_left wins; out_right is ignored.
- POINT:
  - ball_rst=0, ball_run=0 (ball frozen where it left).
  - Go to SERVE after POINT_HOLD_FRAMES ticks, using the same counter rule as SERVE.
- GAME_OVER:
  - game_over=1, ball_rst=1, ball_run=0. Scores and winner are held.
  - On start_edge: clear scores, winner=0, serve_dir=1, counter=0, go to SERVE.
- Event masking and ignored inputs:
  - ball_out_* are ignored outside PLAY.
  - start_edge is ignored in SERVE, PLAY and POINT.
  - timing_tick is ignored in IDLE, PLAY and GAME_OVER.
  - Counter is held at 0 in states that do not count.
- Scores never exceed WIN_SCORE; no wrap-around is possible.
- Illegal state encoding recovers to IDLE on the next clk.
- rst asserted mid-game (any state): back to reset values on the next edge; scores are lost.

Test Plan:
- Reset, then start=1 for 3 cycles -> SERVE entered 1 cycle after the start rise. Scores 0, ball_rst=1. Exactly one transition; start held high does not retrigger.
- SERVE_DELAY_FRAMES=4, drive 4 ticks -> state_dbg goes 1->2 one cycle after the 4th tick. ball_run=1, ball_rst=0. Ticks in PLAY do not change state.
- In PLAY, pulse ball_out_right -> score_left=1, serve_dir=1, POINT. After POINT_HOLD_FRAMES ticks -> SERVE.
- In PLAY, pulse ball_out_left and ball_out_right in the same cycle -> score_right+1 only, score_left unchanged, serve_dir=0.
- Run out_left points until score_right=5 (WIN_SCORE=5) -> GAME_OVER, game_over=1, winner=1. Further out pulses and ticks are ignored. start edge -> scores 0, SERVE.
- Assert rst for 1 cycle during POINT with score 3:2 -> IDLE, scores 0:0, ball_rst=1, ball_run=0. Out pulses in IDLE have no effect.
